spi_byte_slave: RTL and testbench

- Oversampled SPI slave that sits directly upstream of the miner control logic and converts the host's SPI link into a byte stream in the clk domain.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first; SSEL is active-low.
- Presents each received byte as a one-cycle strobe, and loads a host-supplied reply byte for the following byte slot.
- Adds frame delimiting (start/end strobes, byte index) and overrun/abort detection so the miner control logic can reject malformed command frames.

---
 rtl/spi_byte_slave_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_byte_slave.sv | 140 ++++++++++++++
 tb/tb_spi_byte_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_slave_pkg.sv
// Shared definitions for the SPI byte slave and the miner control logic
// downstream of it: protocol byte values, the supported SPI mode, counter
// widths, FSM state codes and a saturating increment helper.
package spi_byte_slave_pkg;

    // Protocol bytes exchanged with the host
    localparam logic [7:0] WAITING    = 8'hA0;
    localparam logic [7:0] WORKING    = 8'hA1;
    localparam logic [7:0] MSG_START  = 8'hA2;
    localparam logic [7:0] GET_STATE  = 8'hA3;
    localparam logic [7:0] GET_MSG    = 8'hA4;
    localparam logic [7:0] DONE       = 8'hA5;
    localparam logic [7:0] DONE_FOUND = 8'hA6;

    // {CPOL, CPHA} of the only supported SPI mode
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_IDX_W = 8;

    // Frame FSM state codes
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [BYTE_IDX_W-1:0] sat_inc(input logic [BYTE_IDX_W-1:0] v);
        return (v == {BYTE_IDX_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a
// history flop that yields single-cycle rise and fall strobes.
// RESET_VAL lets an idle-high signal (ssel) come out of reset without
// producing a spurious edge.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Shift the raw input through the synchroniser and keep one cycle of history
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            hist  <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = sync_out & ~hist;
    assign fall     = ~sync_out & hist;

endmodule

// File: rtl/spi_byte_slave.sv
// Oversampled SPI mode-0 slave (MSB first, active-low ssel) producing a
// byte stream in the clk domain with frame delimiting and abort detection.
// Optional build macro SPI_BYTE_SLAVE_TRISTATE_EN: when defined, miso is
// released to high impedance while deselected or in reset; otherwise it
// is driven low in those conditions.
module spi_byte_slave
    import spi_byte_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hA0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  ssel,
    output logic                  miso,
    output logic                  byte_received,
    output logic [7:0]            received_data,
    output logic                  data_needed,
    input  logic [7:0]            data_to_send,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [BYTE_IDX_W-1:0] byte_index,
    output logic                  frame_error
);

    logic sck_sync, sck_rise, sck_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic ssel_sync, ssel_rise, ssel_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .reset(reset), .async_in(sck),
        .sync_out(sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .async_in(mosi),
        .sync_out(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssel_sync (
        .clk(clk), .reset(reset), .async_in(ssel),
        .sync_out(ssel_sync), .rise(ssel_rise), .fall(ssel_fall)
    );

    // Only the level of mosi and the edges of sck are needed
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_sync, mosi_rise, mosi_fall};

    logic [0:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic [7:0]           reply_reg;
    logic                 miso_reg;
    logic                 first_done;
    logic [7:0]           rx_next;

    assign rx_next = {rx_shift[6:0], mosi_sync};

    // Frame FSM: ssel edges delimit frames, sck rising samples, sck falling shifts out
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= IDLE_BYTE;
            reply_reg     <= IDLE_BYTE;
            miso_reg      <= 1'b0;
            first_done    <= 1'b0;
            byte_received <= 1'b0;
            received_data <= '0;
            data_needed   <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            byte_index    <= '0;
            frame_error   <= 1'b0;
        end else begin
            byte_received <= 1'b0;
            data_needed   <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ssel_fall) begin
                        state       <= ST_SHIFT;
                        frame_start <= 1'b1;
                        bit_cnt     <= '0;
                        byte_index  <= '0;
                        frame_error <= 1'b0;
                        first_done  <= 1'b0;
                        tx_shift    <= reply_reg;
                        miso_reg    <= reply_reg[7];
                    end
                end
                ST_SHIFT: begin
                    if (ssel_rise) begin
                        state     <= ST_IDLE;
                        frame_end <= 1'b1;
                        miso_reg  <= 1'b0;
                        bit_cnt   <= '0;
                        if (bit_cnt != '0) begin
                            frame_error <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            received_data <= rx_next;
                            byte_received <= 1'b1;
                            first_done    <= 1'b1;
                            if (first_done) begin
                                byte_index <= sat_inc(byte_index);
                            end
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            miso_reg <= tx_shift[6];
                        end else begin
                            tx_shift    <= data_to_send;
                            reply_reg   <= data_to_send;
                            miso_reg    <= data_to_send[7];
                            data_needed <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_BYTE_SLAVE_TRISTATE_EN
    assign miso = (ssel_sync || reset) ? 1'bz : miso_reg;
`else
    assign miso = (ssel_sync || reset) ? 1'b0 : miso_reg;
`endif

endmodule

// File: tb/tb_spi_byte_slave.sv
// Self-checking bench for spi_byte_slave: acts as an SPI mode-0 master at
// sck = clk/10 and compares against a frame-level reference model.
module tb_spi_byte_slave;

    localparam int HALF = 5;

`ifdef SPI_BYTE_SLAVE_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sck, mosi, ssel, miso;
    logic       byte_received, data_needed, frame_start, frame_end, frame_error;
    logic [7:0] received_data, data_to_send, byte_index;

    spi_byte_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hA0)) dut (
        .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .ssel(ssel),
        .miso(miso), .byte_received(byte_received), .received_data(received_data),
        .data_needed(data_needed), .data_to_send(data_to_send),
        .frame_start(frame_start), .frame_end(frame_end),
        .byte_index(byte_index), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Monitor log of strobes and captured outputs
    logic [7:0] rx_log [0:1023];
    logic [7:0] idx_log[0:1023];
    int rx_total = 0, fs_total = 0, fe_total = 0, dn_total = 0;
    int rx_base, fs_base, fe_base, dn_base;

    // Master side stimulus and capture
    logic [7:0] mosi_arr[0:299];
    logic [7:0] rep_arr [0:299];
    logic [7:0] miso_cap[0:299];
    logic [7:0] model_reply;
    logic       err_mid;

    typedef struct {
        logic [7:0] mosi_b;
        logic [7:0] reply_b;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t tbl[5];

    always @(negedge clk) begin
        if (!reset) begin
            if (byte_received) begin
                if (rx_total < 1024) begin
                    rx_log[rx_total]  <= received_data;
                    idx_log[rx_total] <= byte_index;
                end
                rx_total <= rx_total + 1;
            end
            if (frame_start) fs_total <= fs_total + 1;
            if (frame_end)   fe_total <= fe_total + 1;
            if (data_needed) dn_total <= dn_total + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One master frame: nbytes full bytes plus partial_bits of one more byte
    task automatic applyStimulus(input int nbytes, input int partial_bits, input bit hold_open);
        rx_base = rx_total; fs_base = fs_total; fe_base = fe_total; dn_base = dn_total;
        @(negedge clk);
        ssel = 1'b0;
        repeat (8) @(negedge clk);
        err_mid = frame_error;
        for (int b = 0; b <= nbytes; b++) begin
            int nbits;
            nbits = (b < nbytes) ? 8 : partial_bits;
            for (int k = 0; k < nbits; k++) begin
                mosi = mosi_arr[b][7-k];
                repeat (HALF) @(negedge clk);
                miso_cap[b][7-k] = miso;
                sck = 1'b1;
                repeat (HALF - 1) @(negedge clk);
                if (k == 7) data_to_send = rep_arr[b];
                @(negedge clk);
                sck = 1'b0;
            end
        end
        if (!hold_open) begin
            repeat (HALF) @(negedge clk);
            ssel = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    // Frame-level reference: bytes echo mosi, index saturates, reply lags one byte
    task automatic checkFrame(input int nbytes, input int partial_bits);
        logic [7:0] exp_miso;
        checkOutput("rx_count", 32'(rx_total - rx_base), 32'(nbytes));
        for (int b = 0; b < nbytes; b++) begin
            exp_miso = (b == 0) ? model_reply : rep_arr[b-1];
            if (rx_base + b < rx_total) begin
                checkOutput("rx_data", 32'(rx_log[rx_base+b]), 32'(mosi_arr[b]));
                checkOutput("byte_index", 32'(idx_log[rx_base+b]), 32'((b > 255) ? 255 : b));
            end
            checkOutput("miso_byte", 32'(miso_cap[b]), 32'(exp_miso));
        end
        checkOutput("frame_start_cnt", 32'(fs_total - fs_base), 32'd1);
        checkOutput("frame_end_cnt", 32'(fe_total - fe_base), 32'd1);
        checkOutput("data_needed_cnt", 32'(dn_total - dn_base), 32'(nbytes));
        checkOutput("frame_error", 32'(frame_error), 32'(partial_bits != 0));
        if (nbytes > 0) model_reply = rep_arr[nbytes-1];
    endtask

    initial begin
        int n, p;
        tbl[0] = '{8'hA2, 8'h11, 8'hA2, 8'hA0};
        tbl[1] = '{8'h3C, 8'h22, 8'h3C, 8'h11};
        tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'h22};
        tbl[3] = '{8'h00, 8'h5A, 8'h00, 8'h00};
        tbl[4] = '{8'h81, 8'hA5, 8'h81, 8'h5A};

        reset = 1'b1; sck = 1'b0; mosi = 1'b0; ssel = 1'b1; data_to_send = 8'h00;
        model_reply = 8'hA0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_received_data", 32'(received_data), 32'h0);
        checkOutput("rst_byte_index", 32'(byte_index), 32'h0);
        checkOutput("rst_frame_error", 32'(frame_error), 32'h0);
        checkOutput("rst_byte_received", 32'(byte_received), 32'h0);
        checkOutput("rst_miso", 32'(miso), 32'(MISO_IDLE));

        $display("[TB] single-byte vector table");
        for (int i = 0; i < 5; i++) begin
            mosi_arr[0] = tbl[i].mosi_b;
            rep_arr[0]  = tbl[i].reply_b;
            applyStimulus(1, 0, 1'b0);
            checkOutput("tbl_rx", 32'(rx_log[rx_base]), 32'(tbl[i].exp_rx));
            checkOutput("tbl_miso", 32'(miso_cap[0]), 32'(tbl[i].exp_miso));
            checkFrame(1, 0);
        end

        $display("[TB] reply loaded after byte 0");
        mosi_arr[0] = 8'hA3; mosi_arr[1] = 8'hA4;
        rep_arr[0] = 8'h5C;  rep_arr[1] = 8'($urandom);
        applyStimulus(2, 0, 1'b0);
        checkOutput("reply_5c", 32'(miso_cap[1]), 32'h5C);
        checkFrame(2, 0);

        $display("[TB] 76-byte frame");
        for (int i = 0; i < 76; i++) begin
            mosi_arr[i] = 8'(i);
            rep_arr[i]  = 8'($urandom);
        end
        applyStimulus(76, 0, 1'b0);
        checkFrame(76, 0);

        $display("[TB] aborted frame after 5 bits");
        mosi_arr[0] = 8'($urandom);
        applyStimulus(0, 5, 1'b0);
        checkFrame(0, 5);
        mosi_arr[0] = 8'($urandom); mosi_arr[1] = 8'($urandom);
        rep_arr[0]  = 8'($urandom); rep_arr[1]  = 8'($urandom);
        applyStimulus(2, 0, 1'b0);
        checkOutput("err_cleared", 32'(err_mid), 32'h0);
        checkFrame(2, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 6);
            p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i <= n; i++) begin
                mosi_arr[i] = 8'($urandom);
                rep_arr[i]  = 8'($urandom);
            end
            applyStimulus(n, p, 1'b0);
            checkFrame(n, p);
        end

        $display("[TB] 300-byte frame");
        for (int i = 0; i < 300; i++) begin
            mosi_arr[i] = 8'($urandom);
            rep_arr[i]  = 8'($urandom);
        end
        applyStimulus(300, 0, 1'b0);
        checkFrame(300, 0);

        $display("[TB] reset during bit 4 of byte 3");
        for (int i = 0; i < 4; i++) begin
            mosi_arr[i] = 8'($urandom_range(1, 255));
            rep_arr[i]  = 8'($urandom);
        end
        applyStimulus(3, 4, 1'b1);
        mosi = mosi_arr[3][3];
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_rx", 32'(received_data), 32'(mosi_arr[2]));
        checkOutput("pre_rst_index", 32'(byte_index), 32'd2);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_received_data", 32'(received_data), 32'h0);
        checkOutput("mid_rst_byte_index", 32'(byte_index), 32'h0);
        checkOutput("mid_rst_frame_error", 32'(frame_error), 32'h0);
        checkOutput("mid_rst_strobes", 32'({byte_received, data_needed, frame_start, frame_end}), 32'h0);
        checkOutput("mid_rst_miso", 32'(miso), 32'(MISO_IDLE));
        ssel = 1'b1; sck = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("no_frame_end_after_rst", 32'(fe_total - fe_base), 32'h0);
        checkOutput("post_rst_miso", 32'(miso), 32'(MISO_IDLE));
        model_reply = 8'hA0;
        mosi_arr[0] = 8'hA4;
        rep_arr[0]  = 8'($urandom);
        applyStimulus(1, 0, 1'b0);
        checkFrame(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
